// File: rtl/audio_volume.sv
// Volume stage: pops a sample, scales it by a ramped Q-format gain, shifts and pushes it.
// Optional output clamping with a sticky flag is enabled by defining AUDIO_VOLUME_SAT_EN.
module audio_volume #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned GAIN_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 10,
  parameter int unsigned OUT_SHIFT  = 4,
  parameter int unsigned RAMP_STEP  = 4,
  parameter int unsigned GAIN_RESET = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  x_in_rd_en,
  input  logic                  x_in_empty,
  input  logic [DATA_WIDTH-1:0] x_in,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic                  y_out_wr_en,
  input  logic                  y_out_full,
  input  logic [GAIN_WIDTH-1:0] gain_target,
  input  logic                  mute,
  output logic [GAIN_WIDTH-1:0] gain_cur,
  output logic                  sat_flag
);

  localparam int unsigned PW = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int unsigned RW = PW + OUT_SHIFT;

  localparam logic signed [PW-1:0]   RoundBias = PW'((1 << FRAC_BITS) - 1);
  localparam logic [GAIN_WIDTH:0]    Step      = (GAIN_WIDTH + 1)'(RAMP_STEP);
  localparam logic [GAIN_WIDTH-1:0]  GainInit  = GAIN_WIDTH'(GAIN_RESET);

  typedef enum logic [1:0] {StRead, StMult, StWrite} state_e;

  state_e                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   x_q, x_d;
  logic signed [RW-1:0]           r_q, r_d;
  logic [GAIN_WIDTH-1:0]          gain_q, gain_d;

  logic signed [PW-1:0]           prod;
  logic signed [PW-1:0]           quot;
  logic signed [RW-1:0]           r_ext;
  logic [GAIN_WIDTH-1:0]          gain_tgt;
  logic [GAIN_WIDTH:0]            gain_diff;
  logic [GAIN_WIDTH-1:0]          gain_ramped;
  logic [DATA_WIDTH-1:0]          y_red;
  logic                           push;

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRead;
      x_q     <= '0;
      r_q     <= '0;
      gain_q  <= GainInit;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      r_q     <= r_d;
      gain_q  <= gain_d;
    end
  end

  // ---------------- datapath ----------------
  always_comb begin
    prod  = $signed(PW'(x_q)) * $signed({{(PW - GAIN_WIDTH){1'b0}}, gain_q});
    // Bias negatives so the arithmetic shift truncates toward zero.
    quot  = (prod + (prod[PW-1] ? RoundBias : '0)) >>> FRAC_BITS;
    r_ext = RW'(quot);
  end

  // Ramp toward the target without ever wrapping the gain register.
  always_comb begin
    gain_tgt    = mute ? '0 : gain_target;
    gain_diff   = '0;
    gain_ramped = gain_q;
    if (gain_q < gain_tgt) begin
      gain_diff   = {1'b0, gain_tgt} - {1'b0, gain_q};
      gain_ramped = (gain_diff > Step) ? gain_q + Step[GAIN_WIDTH-1:0] : gain_tgt;
    end else if (gain_q > gain_tgt) begin
      gain_diff   = {1'b0, gain_q} - {1'b0, gain_tgt};
      gain_ramped = (gain_diff > Step) ? gain_q - Step[GAIN_WIDTH-1:0] : gain_tgt;
    end
  end

  // ---------------- next-state ----------------
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    r_d     = r_q;
    gain_d  = gain_q;
    unique case (state_q)
      StRead: begin
        if (!x_in_empty) begin
          x_d     = x_in;
          state_d = StMult;
        end
      end
      StMult: begin
        r_d     = r_ext <<< OUT_SHIFT;
        state_d = StWrite;
      end
      StWrite: begin
        if (!y_out_full) begin
          gain_d  = gain_ramped;
          state_d = StRead;
        end
      end
      default: state_d = StRead;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    x_in_rd_en  = (state_q == StRead) && !x_in_empty;
    push        = (state_q == StWrite) && !y_out_full;
    y_out_wr_en = push;
    y_out       = push ? y_red : '0;
    gain_cur    = gain_q;
  end

`ifdef AUDIO_VOLUME_SAT_EN
  localparam logic signed [RW-1:0] YMax = {{(RW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [RW-1:0] YMin = {{(RW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  logic sat_hi, sat_lo;
  logic sat_q, sat_d;

  always_comb begin
    sat_hi = r_q > YMax;
    sat_lo = r_q < YMin;
    if (sat_hi) begin
      y_red = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (sat_lo) begin
      y_red = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end else begin
      y_red = r_q[DATA_WIDTH-1:0];
    end
    sat_d = sat_q | (push & (sat_hi | sat_lo));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_flag = sat_q;
`else
  logic unused_r_hi;

  assign y_red       = r_q[DATA_WIDTH-1:0];
  assign unused_r_hi = ^r_q[RW-1:DATA_WIDTH];
  assign sat_flag    = 1'b0;
`endif

endmodule

// File: tb/tb_audio_volume.sv
// Self-checking bench for audio_volume: directed steps plus randomized samples against
// an arithmetic reference model of the gain ramp, scaling and output reduction.
module tb_audio_volume;

  localparam int DW    = 32;
  localparam int GW    = 16;
  localparam int FRAC  = 10;
  localparam int SHIFT = 4;
  localparam int STEP  = 4;
  localparam int GRST  = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          x_in_rd_en;
  logic          x_in_empty;
  logic [DW-1:0] x_in;
  logic [DW-1:0] y_out;
  logic          y_out_wr_en;
  logic          y_out_full;
  logic [GW-1:0] gain_target;
  logic          mute;
  logic [GW-1:0] gain_cur;
  logic          sat_flag;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int   mg = GRST;
  logic ms = 1'b0;

  audio_volume dut (
    .clk         (clk),
    .rst         (rst),
    .x_in_rd_en  (x_in_rd_en),
    .x_in_empty  (x_in_empty),
    .x_in        (x_in),
    .y_out       (y_out),
    .y_out_wr_en (y_out_wr_en),
    .y_out_full  (y_out_full),
    .gain_target (gain_target),
    .mute        (mute),
    .gain_cur    (gain_cur),
    .sat_flag    (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_y(input logic [DW-1:0] x);
    longint p, q, r;
    p = longint'($signed(x)) * longint'(mg);
    q = p / (longint'(1) << FRAC);
    r = q * (longint'(1) << SHIFT);
`ifdef AUDIO_VOLUME_SAT_EN
    if (r > 64'sd2147483647) begin
      ms = 1'b1;
      return 32'h7FFF_FFFF;
    end
    if (r < -64'sd2147483648) begin
      ms = 1'b1;
      return 32'h8000_0000;
    end
`endif
    return r[DW-1:0];
  endfunction

  function automatic void model_ramp();
    int t;
    t = mute ? 0 : int'(gain_target);
    if (mg < t) mg = (mg + STEP < t) ? mg + STEP : t;
    else if (mg > t) mg = (mg - STEP > t) ? mg - STEP : t;
  endfunction

  // One sample: idle cycles with empty, pop, optional stall in WRITE, push, post-push checks.
  task automatic run_sample(input logic [DW-1:0] x, input int stall, input int idle);
    int            n;
    logic [DW-1:0] exp_y;
    logic          mute_keep;
    @(negedge clk);
    x_in_empty = 1'b1;
    y_out_full = (stall > 0);
    for (int i = 0; i < idle; i++) begin
      x_in = $urandom;
      @(negedge clk); #1;
      check("idle_no_pop", {63'b0, x_in_rd_en}, 64'd0);
    end
    x_in = x;
    x_in_empty = 1'b0;
    #1;
    n = 0;
    while (!x_in_rd_en && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
    check("pop", {63'b0, x_in_rd_en}, 64'd1);
    @(posedge clk); #1;
    x_in = $urandom;
    x_in_empty = 1'($urandom_range(0, 1));
    #1;
    check("mult_no_pop", {63'b0, x_in_rd_en}, 64'd0);
    check("mult_no_push", {63'b0, y_out_wr_en}, 64'd0);
    @(posedge clk); #1;
    mute_keep = mute;
    for (int i = 0; i < stall; i++) begin
      x_in_empty = 1'($urandom_range(0, 1));
      mute = ~mute_keep;
      #1;
      check("stall_no_push", {63'b0, y_out_wr_en}, 64'd0);
      check("stall_no_pop", {63'b0, x_in_rd_en}, 64'd0);
      check("stall_y_zero", {32'b0, y_out}, 64'd0);
      @(posedge clk); #1;
    end
    mute = mute_keep;
    if (stall > 0) check("stall_gain_hold", {48'b0, gain_cur}, 64'(mg));
    y_out_full = 1'b0;
    #1;
    exp_y = model_y(x);
    check("push", {63'b0, y_out_wr_en}, 64'd1);
    check("y_out", {32'b0, y_out}, {32'b0, exp_y});
    model_ramp();
    @(posedge clk); #1;
    x_in_empty = 1'b1;
    #1;
    check("gain_cur", {48'b0, gain_cur}, 64'(mg));
    check("y_idle_zero", {32'b0, y_out}, 64'd0);
    check("sat_flag", {63'b0, sat_flag}, {63'b0, ms});
  endtask

  task automatic ramp_to(input int tgt);
    gain_target = GW'(tgt);
    mute = 1'b0;
    for (int i = 0; i < 1200 && mg != tgt; i++) begin
      run_sample(DW'($urandom_range(0, 2 ** 20)) - DW'(2 ** 19), 0, 0);
    end
    check("ramp_reached", 64'(mg), 64'(tgt));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    x_in_empty = 1'b1;
    x_in = '0;
    y_out_full = 1'b0;
    gain_target = GW'(GRST);
    mute = 1'b0;
    #12;
    check("rst_gain", {48'b0, gain_cur}, 64'(GRST));
    check("rst_y", {32'b0, y_out}, 64'd0);
    check("rst_wr_en", {63'b0, y_out_wr_en}, 64'd0);
    check("rst_rd_en", {63'b0, x_in_rd_en}, 64'd0);
    check("rst_sat", {63'b0, sat_flag}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Unity gain
    run_sample(32'd1000, 0, 2);
    check("unity_gain_hold", {48'b0, gain_cur}, 64'd1024);

    // Truncation toward zero for negatives
    ramp_to(512);
    run_sample(32'hFFFF_FFFF, 0, 0);
    ramp_to(1024);
    run_sample(-32'sd1025, 0, 1);

    // Ramp up to a nearby target
    gain_target = 16'd1034;
    for (int i = 0; i < 4; i++) run_sample(32'd1024, 0, 0);
    check("ramp_1034", {48'b0, gain_cur}, 64'd1034);

    // Mute ramps down to zero
    mute = 1'b1;
    for (int i = 0; i < 400 && mg != 0; i++) run_sample($urandom, 0, 0);
    check("mute_zero", {48'b0, gain_cur}, 64'd0);
    mute = 1'b0;

    // Backpressure
    ramp_to(1024);
    run_sample(32'd777, 10, 0);
    run_sample(-32'sd5000, 3, 2);

    // Large gain, full-scale input
    ramp_to(2048);
    run_sample(32'h7FFF_FFFF, 0, 0);
    run_sample(32'd100, 0, 0);

    // Reset while in MULT discards the pending sample
    @(negedge clk);
    x_in = 32'd1234;
    x_in_empty = 1'b0;
    #1;
    check("rst_case_pop", {63'b0, x_in_rd_en}, 64'd1);
    @(posedge clk); #1;
    x_in_empty = 1'b1;
    rst = 1'b1;
    #1;
    mg = GRST;
    ms = 1'b0;
    check("midrst_gain", {48'b0, gain_cur}, 64'(GRST));
    check("midrst_sat", {63'b0, sat_flag}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (y_out_wr_en) n++;
    end
    check("midrst_no_push", 64'(n), 64'd0);
    gain_target = GW'(GRST);
    run_sample(32'd1000, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      gain_target = GW'($urandom_range(0, 4096));
      mute = ($urandom_range(0, 7) == 0);
      run_sample($urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
